// File: rtl/cva6_clic_irq_arbiter.sv
// ---------------------------------------------------------------------------
// cva6_clic_irq_arbiter
// Source-side CLIC arbiter placed directly upstream of the core's CLIC
// interrupt controller. Each cycle it finds the best pending, enabled source
// and presents it as a registered valid/id/level/priv request. It tracks
// acceptance through irq_ready_i and pulses irq_clr_o for the accepted
// source. A request that goes stale or is outranked is withdrawn through the
// irq_kill_req_o / irq_kill_ack_i handshake.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   irq_pending_i   per-source pending bit
//   irq_enable_i    per-source enable bit
//   irq_level_i     per-source 8-bit level, source k at [8k+7:8k]
//   irq_priv_i      per-source 2-bit privilege, source k at [2k+1:2k]
//   irq_valid_o     request to core valid
//   irq_id_o        ID of presented request
//   irq_level_o     level of presented request
//   irq_priv_o      privilege of presented request
//   irq_ready_i     core accepted presented request
//   irq_kill_req_o  ask core to drop the presented request
//   irq_kill_ack_i  core confirms the drop
//   irq_clr_o       one-cycle pulse: clear pending of irq_clr_id_o
//   irq_clr_id_o    ID to clear
// ---------------------------------------------------------------------------
module cva6_clic_irq_arbiter #(
    parameter int unsigned NumSrc  = 64,
    parameter int unsigned IdWidth = $clog2(NumSrc)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumSrc-1:0]     irq_pending_i,
    input  logic [NumSrc-1:0]     irq_enable_i,
    input  logic [NumSrc*8-1:0]   irq_level_i,
    input  logic [NumSrc*2-1:0]   irq_priv_i,
    output logic                  irq_valid_o,
    output logic [IdWidth-1:0]    irq_id_o,
    output logic [7:0]            irq_level_o,
    output logic [1:0]            irq_priv_o,
    input  logic                  irq_ready_i,
    output logic                  irq_kill_req_o,
    input  logic                  irq_kill_ack_i,
    output logic                  irq_clr_o,
    output logic [IdWidth-1:0]    irq_clr_id_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESENT = 2'b01,
        KILL    = 2'b10
    } state_e;

    state_e               state_r, state_nxt_s;

    logic                 valid_r, valid_nxt_s;
    logic                 kill_req_r, kill_req_nxt_s;
    logic                 clr_r, clr_nxt_s;
    logic [IdWidth-1:0]   clr_id_r, clr_id_nxt_s;
    logic [IdWidth-1:0]   id_r, id_nxt_s;
    logic [7:0]           level_r, level_nxt_s;
    logic [1:0]           priv_r, priv_nxt_s;

    logic [NumSrc-1:0]    cand_s;
    logic                 any_cand_s;
    logic [IdWidth-1:0]   best_id_s;
    logic [9:0]           best_key_s;
    logic [9:0]           latched_key_s;

    // Combinational winner search: highest {priv,level}; ascending scan with a
    // strict compare keeps the lowest ID on equal keys. Reserved priv never wins.
    always_comb begin
        cand_s     = {NumSrc{1'b0}};
        any_cand_s = 1'b0;
        best_id_s  = {IdWidth{1'b0}};
        best_key_s = 10'd0;
        for (int k = 0; k < int'(NumSrc); k++) begin
            cand_s[k] = irq_pending_i[k] & irq_enable_i[k] & (irq_priv_i[2*k +: 2] != 2'b10);
            if (cand_s[k] && (!any_cand_s || ({irq_priv_i[2*k +: 2], irq_level_i[8*k +: 8]} > best_key_s))) begin
                any_cand_s = 1'b1;
                best_id_s  = IdWidth'(k);
                best_key_s = {irq_priv_i[2*k +: 2], irq_level_i[8*k +: 8]};
            end else begin
                any_cand_s = any_cand_s;
            end
        end
    end

    assign latched_key_s = {priv_r, level_r};

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        state_nxt_s    = state_r;
        valid_nxt_s    = valid_r;
        kill_req_nxt_s = kill_req_r;
        clr_nxt_s      = 1'b0;
        clr_id_nxt_s   = clr_id_r;
        id_nxt_s       = id_r;
        level_nxt_s    = level_r;
        priv_nxt_s     = priv_r;
        case (state_r)
            IDLE: begin
                valid_nxt_s    = 1'b0;
                kill_req_nxt_s = 1'b0;
                if (any_cand_s) begin
                    state_nxt_s = PRESENT;
                    valid_nxt_s = 1'b1;
                    id_nxt_s    = best_id_s;
                    level_nxt_s = best_key_s[7:0];
                    priv_nxt_s  = best_key_s[9:8];
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESENT: begin
                // Acceptance outranks any withdrawal decided in the same cycle.
                if (irq_ready_i) begin
                    state_nxt_s  = IDLE;
                    valid_nxt_s  = 1'b0;
                    clr_nxt_s    = 1'b1;
                    clr_id_nxt_s = id_r;
                end else if (!cand_s[id_r] || (best_key_s > latched_key_s)) begin
                    state_nxt_s    = KILL;
                    valid_nxt_s    = 1'b0;
                    kill_req_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            KILL: begin
                // The core may already have taken the request; that counts as
                // an acceptance and must still clear the source.
                if (irq_ready_i) begin
                    state_nxt_s    = IDLE;
                    kill_req_nxt_s = 1'b0;
                    clr_nxt_s      = 1'b1;
                    clr_id_nxt_s   = id_r;
                end else if (irq_kill_ack_i) begin
                    state_nxt_s    = IDLE;
                    kill_req_nxt_s = 1'b0;
                end else begin
                    kill_req_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                valid_nxt_s    = 1'b0;
                kill_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            kill_req_r <= 1'b0;
            clr_r      <= 1'b0;
            clr_id_r   <= {IdWidth{1'b0}};
            id_r       <= {IdWidth{1'b0}};
            level_r    <= 8'h00;
            priv_r     <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            valid_r    <= valid_nxt_s;
            kill_req_r <= kill_req_nxt_s;
            clr_r      <= clr_nxt_s;
            clr_id_r   <= clr_id_nxt_s;
            id_r       <= id_nxt_s;
            level_r    <= level_nxt_s;
            priv_r     <= priv_nxt_s;
        end
    end

    assign irq_valid_o    = valid_r;
    assign irq_id_o       = id_r;
    assign irq_level_o    = level_r;
    assign irq_priv_o     = priv_r;
    assign irq_kill_req_o = kill_req_r;
    assign irq_clr_o      = clr_r;
    assign irq_clr_id_o   = clr_id_r;

endmodule
